// File: rtl/gpu_pkg.sv
// Shared constants for the compute core: state encodings and
// default program memory widths.
package gpu_pkg;

    localparam int DEF_ADDR_BITS = 8;
    localparam int DEF_DATA_BITS = 16;

    localparam logic [2:0] FS_IDLE    = 3'b000;
    localparam logic [2:0] FS_LOOKUP  = 3'b001;
    localparam logic [2:0] FS_MISS    = 3'b011;
    localparam logic [2:0] FS_FETCHED = 3'b010;

    localparam logic [2:0] CS_IDLE    = 3'b000;
    localparam logic [2:0] CS_FETCH   = 3'b001;
    localparam logic [2:0] CS_DECODE  = 3'b010;
    localparam logic [2:0] CS_REQUEST = 3'b011;
    localparam logic [2:0] CS_WAIT    = 3'b100;
    localparam logic [2:0] CS_EXECUTE = 3'b101;
    localparam logic [2:0] CS_UPDATE  = 3'b110;
    localparam logic [2:0] CS_DONE    = 3'b111;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped instruction cache storage: combinational read,
// synchronous fill, single-cycle bulk invalidate.
module icache_array
    import gpu_pkg::*;
#(
    parameter int LINES     = 8,
    parameter int TAG_BITS  = 5,
    parameter int DATA_BITS = DEF_DATA_BITS,
    localparam int IDX_BITS = $clog2(LINES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic [IDX_BITS-1:0]  rd_idx_i,
    output logic                 rd_valid_o,
    output logic [TAG_BITS-1:0]  rd_tag_o,
    output logic [DATA_BITS-1:0] rd_data_o,
    input  logic                 wr_en_i,
    input  logic [IDX_BITS-1:0]  wr_idx_i,
    input  logic [TAG_BITS-1:0]  wr_tag_i,
    input  logic [DATA_BITS-1:0] wr_data_i
);

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [DATA_BITS-1:0] data_q [LINES];

    // Clear beats a same-cycle fill so a stale line never survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/fetcher_icache.sv
// Instruction fetch stage with a direct-mapped instruction cache
// in front of a valid/ready program memory port.
module fetcher_icache
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = DEF_ADDR_BITS,
    parameter int PROGRAM_MEM_DATA_BITS = DEF_DATA_BITS,
    parameter int CACHE_LINES           = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             invalidate,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [15:0]                      hit_count,
    output logic [15:0]                      miss_count
);

    localparam int IDX_BITS = $clog2(CACHE_LINES);
    localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;
    localparam int AW = PROGRAM_MEM_ADDR_BITS;
    localparam int DW = PROGRAM_MEM_DATA_BITS;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          req_q, req_d;
    logic [DW-1:0] instr_q, instr_d;
    logic [15:0]   hit_cnt_q, hit_cnt_d;
    logic [15:0]   miss_cnt_q, miss_cnt_d;

    logic                rd_valid;
    logic [TAG_BITS-1:0] rd_tag;
    logic [DW-1:0]       rd_data;
    logic                wr_en;
    logic                lookup_hit;

    logic [IDX_BITS-1:0] pc_idx;
    logic [TAG_BITS-1:0] pc_tag;

    assign pc_idx = pc_q[IDX_BITS-1:0];
    assign pc_tag = pc_q[AW-1:IDX_BITS];

    icache_array #(
        .LINES     (CACHE_LINES),
        .TAG_BITS  (TAG_BITS),
        .DATA_BITS (DW)
    ) u_array (
        .clk        (clk),
        .rst_n      (reset),
        .clear_i    (invalidate),
        .rd_idx_i   (pc_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_idx_i   (pc_idx),
        .wr_tag_i   (pc_tag),
        .wr_data_i  (mem_read_data)
    );

    // An invalidate seen during lookup must not be bypassed by a hit.
    assign lookup_hit = rd_valid && (rd_tag == pc_tag) && !invalidate;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        instr_d    = instr_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wr_en      = 1'b0;
        unique case (state_q)
            FS_IDLE: begin
                if (core_state == CS_FETCH) begin
                    pc_d    = current_pc;
                    state_d = FS_LOOKUP;
                end
            end
            FS_LOOKUP: begin
                if (lookup_hit) begin
                    instr_d = rd_data;
                    if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
                    state_d = FS_FETCHED;
                end else begin
                    req_d  = 1'b1;
                    addr_d = pc_q;
                    if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
                    state_d = FS_MISS;
                end
            end
            FS_MISS: begin
                if (mem_read_ready) begin
                    instr_d = mem_read_data;
                    wr_en   = !invalidate;
                    req_d   = 1'b0;
                    state_d = FS_FETCHED;
                end
            end
            FS_FETCHED: begin
                if (core_state == CS_DECODE) state_d = FS_IDLE;
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FS_IDLE;
            pc_q       <= '0;
            addr_q     <= '0;
            req_q      <= 1'b0;
            instr_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            instr_q    <= instr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign mem_read_valid   = req_q;
    assign mem_read_address = addr_q;
    assign fetcher_state    = state_q;
    assign instruction      = instr_q;
    assign hit_count        = hit_cnt_q;
    assign miss_count       = miss_cnt_q;

endmodule

// File: tb/tb_fetcher_icache.sv
// Randomized self-checking bench for fetcher_icache against a
// line-level cache model (per-line full pc, data, valid).
module tb_fetcher_icache;
    import gpu_pkg::*;

    localparam int LINES = 8;

    logic        clk;
    logic        rst_n;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        invalidate;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checks = 0;
    int errors = 0;

    bit          mvalid [LINES];
    logic [7:0]  mpc    [LINES];
    logic [15:0] mdata  [LINES];
    int          mhits;
    int          mmiss;

    fetcher_icache #(
        .PROGRAM_MEM_ADDR_BITS (8),
        .PROGRAM_MEM_DATA_BITS (16),
        .CACHE_LINES           (LINES)
    ) dut (
        .clk              (clk),
        .reset            (rst_n),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .invalidate       (invalidate),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
        mhits = 0;
        mmiss = 0;
    endfunction

    function automatic void model_inval();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endfunction

    task automatic chk_state(input string nm, input logic [2:0] exp);
        checks++;
        if (fetcher_state !== exp) begin
            errors++;
            $display("FAIL %s state got %0h exp %0h", nm, fetcher_state, exp);
        end
    endtask

    task automatic chk_counts(input string nm);
        checks++;
        if (hit_count !== 16'(mhits) || miss_count !== 16'(mmiss)) begin
            errors++;
            $display("FAIL %s counts got hit=%0d miss=%0d exp hit=%0d miss=%0d",
                     nm, hit_count, miss_count, mhits, mmiss);
        end
    endtask

    // One full FETCH visit; lat = cycles mem_read_valid stays high on a miss.
    task automatic do_fetch(input logic [7:0] pc, input int lat,
                            input bit inv_lk, input bit inv_fill,
                            input logic [15:0] d, input string nm);
        int          idx;
        bit          hit;
        logic [15:0] exp_instr;
        idx = int'(pc) % LINES;
        @(negedge clk);
        core_state = CS_FETCH;
        current_pc = pc;
        @(negedge clk);
        chk_state({nm, "/lookup"}, FS_LOOKUP);
        core_state = CS_REQUEST;
        current_pc = 8'($urandom);
        invalidate = inv_lk;
        hit = !inv_lk && mvalid[idx] && (mpc[idx] == pc);
        if (inv_lk) model_inval();
        @(negedge clk);
        invalidate = 1'b0;
        if (hit) begin
            mhits = (mhits < 65535) ? mhits + 1 : 65535;
            exp_instr = mdata[idx];
            chk_state({nm, "/hit"}, FS_FETCHED);
            checks++;
            if (mem_read_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s/hit_noreq valid got %b exp 0", nm, mem_read_valid);
            end
        end else begin
            mmiss = (mmiss < 65535) ? mmiss + 1 : 65535;
            for (int i = 0; i < lat; i++) begin
                if (i > 0) @(negedge clk);
                chk_state({nm, "/miss"}, FS_MISS);
                checks++;
                if (mem_read_valid !== 1'b1 || mem_read_address !== pc) begin
                    errors++;
                    $display("FAIL %s/req cyc%0d got v=%b a=%0h exp v=1 a=%0h",
                             nm, i, mem_read_valid, mem_read_address, pc);
                end
            end
            mem_read_ready = 1'b1;
            mem_read_data  = d;
            invalidate     = inv_fill;
            @(negedge clk);
            mem_read_ready = 1'b0;
            mem_read_data  = 16'($urandom);
            invalidate     = 1'b0;
            if (inv_fill) begin
                model_inval();
            end else begin
                mvalid[idx] = 1'b1;
                mpc[idx]    = pc;
                mdata[idx]  = d;
            end
            exp_instr = d;
            chk_state({nm, "/fill"}, FS_FETCHED);
            checks++;
            if (mem_read_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s/drop valid got %b exp 0", nm, mem_read_valid);
            end
        end
        checks++;
        if (instruction !== exp_instr) begin
            errors++;
            $display("FAIL %s/instr got %0h exp %0h", nm, instruction, exp_instr);
        end
        chk_counts(nm);
        core_state = CS_EXECUTE;
        @(negedge clk);
        chk_state({nm, "/hold"}, FS_FETCHED);
        checks++;
        if (instruction !== exp_instr) begin
            errors++;
            $display("FAIL %s/stable got %0h exp %0h", nm, instruction, exp_instr);
        end
        core_state = CS_DECODE;
        @(negedge clk);
        chk_state({nm, "/decode"}, FS_IDLE);
        core_state = CS_IDLE;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        core_state = CS_IDLE;
        current_pc = 8'h00;
        invalidate = 1'b0;
        mem_read_ready = 1'b0;
        mem_read_data = 16'h0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_state("reset", FS_IDLE);
        checks++;
        if (mem_read_valid !== 1'b0 || mem_read_address !== 8'h00 ||
            instruction !== 16'h0) begin
            errors++;
            $display("FAIL reset outs got v=%b a=%0h i=%0h exp 0 0 0",
                     mem_read_valid, mem_read_address, instruction);
        end
        chk_counts("reset");
        rst_n = 1'b1;
    endtask

    task automatic test_cold_miss();
        do_fetch(8'h05, 3, 1'b0, 1'b0, 16'hA1B2, "cold");
        checks++;
        if (miss_count !== 16'd1 || instruction !== 16'hA1B2) begin
            errors++;
            $display("FAIL cold_abs got m=%0d i=%0h exp 1 a1b2", miss_count, instruction);
        end
    endtask

    task automatic test_hit();
        do_fetch(8'h05, 1, 1'b0, 1'b0, 16'hDEAD, "hit");
        checks++;
        if (hit_count !== 16'd1 || instruction !== 16'hA1B2) begin
            errors++;
            $display("FAIL hit_abs got h=%0d i=%0h exp 1 a1b2", hit_count, instruction);
        end
    endtask

    task automatic test_conflict();
        do_fetch(8'h0D, 2, 1'b0, 1'b0, 16'h1111, "conf_0d");
        do_fetch(8'h05, 2, 1'b0, 1'b0, 16'hA1B2, "conf_05");
        checks++;
        if (miss_count !== 16'd3) begin
            errors++;
            $display("FAIL conflict_miss got %0d exp 3", miss_count);
        end
    endtask

    task automatic test_invalidate();
        do_fetch(8'h05, 1, 1'b0, 1'b0, 16'h0, "inv_pre");
        @(negedge clk);
        invalidate = 1'b1;
        model_inval();
        @(negedge clk);
        invalidate = 1'b0;
        do_fetch(8'h05, 2, 1'b0, 1'b1, 16'h7E57, "inv_idle");
        do_fetch(8'h05, 1, 1'b0, 1'b0, 16'h2222, "inv_fill");
        do_fetch(8'h05, 1, 1'b1, 1'b0, 16'h3333, "inv_lookup");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            do_fetch(8'($urandom_range(0, 23)), int'($urandom_range(1, 4)),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                     16'($urandom), "rand");
        end
    endtask

    task automatic test_saturation();
        do_fetch(8'h40, 1, 1'b0, 1'b0, 16'hBEEF, "sat_fill");
        @(negedge clk);
        force dut.hit_cnt_q = 16'hFFFD;
        #1;
        release dut.hit_cnt_q;
        mhits = 65533;
        for (int n = 0; n < 4; n++) do_fetch(8'h40, 1, 1'b0, 1'b0, 16'h0, "sat");
        checks++;
        if (hit_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturate got %0h exp ffff", hit_count);
        end
    endtask

    task automatic test_reset_mid_miss();
        @(negedge clk);
        invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
        model_inval();
        core_state = CS_FETCH;
        current_pc = 8'h33;
        repeat (2) @(negedge clk);
        core_state = CS_IDLE;
        chk_state("rmid/miss", FS_MISS);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (mem_read_valid !== 1'b0 || fetcher_state !== FS_IDLE) begin
            errors++;
            $display("FAIL rmid_async got v=%b s=%0h exp 0 0", mem_read_valid, fetcher_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_read_ready = 1'b1;
        mem_read_data = 16'h5A5A;
        @(negedge clk);
        mem_read_ready = 1'b0;
        chk_state("rmid/late_ready", FS_IDLE);
        checks++;
        if (mem_read_valid !== 1'b0 || instruction !== 16'h0) begin
            errors++;
            $display("FAIL rmid_outs got v=%b i=%0h exp 0 0", mem_read_valid, instruction);
        end
        chk_counts("rmid");
        do_fetch(8'h33, 2, 1'b0, 1'b0, 16'h4444, "rmid_after");
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_invalidate();
        test_random();
        test_saturation();
        test_reset_mid_miss();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
